// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, freeze, jump and halt control for a 3-stage 8-bit pipeline
module pipeline_ctrl #(
  parameter int MAX_WAIT = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IF_ID_Instruction_Code,
  input  logic [1:0] ID_EX_Opcode,
  input  logic [2:0] ID_EX_Rd,
  input  logic       Mem_Busy,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       Pipe_Freeze,
  output logic       Jump_Sel,
  output logic [7:0] Jump_Target,
  output logic       Halted,
  output logic       Timeout_Err,
  output logic [7:0] Stall_Cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  logic [1:0] state;
  logic [1:0] next_state;
  logic [3:0] wait_cnt;

  logic [1:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       reads_rs;
  logic       reads_rd;
  logic       hazard;
  logic       is_jump;
  logic       halt_instr;
  logic       timeout_hit;
  logic       stall_event;

  assign op = IF_ID_Instruction_Code[7:6];
  assign rd = IF_ID_Instruction_Code[5:3];
  assign rs = IF_ID_Instruction_Code[2:0];

  // MOV, ADD and LOAD read rs; only ADD also reads rd; JUMP reads nothing.
  assign reads_rs   = (op != OP_JUMP);
  assign reads_rd   = (op == OP_ADD);
  assign hazard     = (ID_EX_Opcode == OP_LOAD) &&
                      ((reads_rs && (ID_EX_Rd == rs)) || (reads_rd && (ID_EX_Rd == rd)));
  // 8'hC0 is a JUMP with a zero offset; it is reserved as the halt instruction.
  assign halt_instr = (IF_ID_Instruction_Code == 8'hC0);
  assign is_jump    = (op == OP_JUMP) && (IF_ID_Instruction_Code[5:0] != 6'd0);

  assign Jump_Target = {2'b00, IF_ID_Instruction_Code[5:0]};

  // Control outputs and next state, resolved in priority order HALT > freeze > load-use > jump > normal.
  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    Jump_Sel     = 1'b0;
    Halted       = 1'b0;
    timeout_hit  = 1'b0;
    next_state   = (state == HALT) ? HALT : RUN;
    if (!Reset) begin
      next_state = RUN;
    end else if (state == HALT) begin
      ID_EX_Bubble = 1'b1;
      Halted       = 1'b1;
    end else if (Mem_Busy) begin
      Pipe_Freeze = 1'b1;
      next_state  = state;
      if (wait_cnt == WAIT_LAST) begin
        timeout_hit = 1'b1;
        next_state  = HALT;
      end
    end else if (state == LU_STALL) begin
      // Second stall cycle of a load-use pair; the hazard input is ignored here.
      ID_EX_Bubble = 1'b1;
      next_state   = RUN;
    end else if (hazard) begin
      ID_EX_Bubble = 1'b1;
      next_state   = LU_STALL;
    end else if (halt_instr) begin
      next_state = HALT;
    end else if (is_jump) begin
      Jump_Sel    = 1'b1;
      PC_Write    = 1'b1;
      IF_ID_Flush = 1'b1;
      IF_ID_Write = 1'b1;
    end else begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
    end
  end

  // Cycles entering or sitting in HALT are not counted as stalls.
  assign stall_event = Reset && !PC_Write && (state != HALT) && (next_state != HALT);

  // Controller state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Consecutive Mem_Busy cycle counter, cleared on any idle memory cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= 4'd0;
    end else if (!Mem_Busy) begin
      wait_cnt <= 4'd0;
    end else if ((state != HALT) && (wait_cnt != 4'hF)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Sticky memory timeout flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Timeout_Err <= 1'b0;
    end else if (timeout_hit) begin
      Timeout_Err <= 1'b1;
    end
  end

  // Saturating stall cycle counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Stall_Cnt <= 8'd0;
    end else if (stall_event && (Stall_Cnt != 8'hFF)) begin
      Stall_Cnt <= Stall_Cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       Clk;
  logic       Reset;
  logic [7:0] IF_ID_Instruction_Code;
  logic [1:0] ID_EX_Opcode;
  logic [2:0] ID_EX_Rd;
  logic       Mem_Busy;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Bubble;
  logic       Pipe_Freeze;
  logic       Jump_Sel;
  logic [7:0] Jump_Target;
  logic       Halted;
  logic       Timeout_Err;
  logic [7:0] Stall_Cnt;

  pipeline_ctrl #(.MAX_WAIT(12)) dut (
    .Clk                    (Clk),
    .Reset                  (Reset),
    .IF_ID_Instruction_Code (IF_ID_Instruction_Code),
    .ID_EX_Opcode           (ID_EX_Opcode),
    .ID_EX_Rd               (ID_EX_Rd),
    .Mem_Busy               (Mem_Busy),
    .PC_Write               (PC_Write),
    .IF_ID_Write            (IF_ID_Write),
    .IF_ID_Flush            (IF_ID_Flush),
    .ID_EX_Bubble           (ID_EX_Bubble),
    .Pipe_Freeze            (Pipe_Freeze),
    .Jump_Sel               (Jump_Sel),
    .Jump_Target            (Jump_Target),
    .Halted                 (Halted),
    .Timeout_Err            (Timeout_Err),
    .Stall_Cnt              (Stall_Cnt)
  );

  // ctrl bit order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Jump_Sel, Halted}
  localparam logic [6:0] C_RST   = 7'b0000000;
  localparam logic [6:0] C_NORM  = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_FRZ   = 7'b0000100;
  localparam logic [6:0] C_JMP   = 7'b1110010;
  localparam logic [6:0] C_HLTI  = 7'b0000000;
  localparam logic [6:0] C_HALT  = 7'b0001001;

  typedef struct {
    int         id;
    logic [6:0] ctrl;
    logic       to;
    logic [7:0] sc;
    logic [7:0] jt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs and queue the hand-computed response for that cycle.
  task automatic step(input logic rst, input logic [7:0] ins, input logic [1:0] op,
                      input logic [2:0] rd, input logic busy, input logic [6:0] ctrl,
                      input logic to, input logic [7:0] sc, input logic [7:0] jt);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset                  = rst;
    IF_ID_Instruction_Code = ins;
    ID_EX_Opcode           = op;
    ID_EX_Rd               = rd;
    Mem_Busy               = busy;
    e.id   = vec_id;
    e.ctrl = ctrl;
    e.to   = to;
    e.sc   = sc;
    e.jt   = jt;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Jump_Sel, Halted};
      checks++;
      if (act !== e.ctrl || Timeout_Err !== e.to || Stall_Cnt !== e.sc || Jump_Target !== e.jt) begin
        errors++;
        $display("FAIL vec%0d: ctrl=%b to=%b stall=%0d jt=%h, want ctrl=%b to=%b stall=%0d jt=%h",
                 e.id, act, Timeout_Err, Stall_Cnt, Jump_Target, e.ctrl, e.to, e.sc, e.jt);
      end
    end
  end

  initial begin
    Reset = 1'b0;
    IF_ID_Instruction_Code = 8'h00;
    ID_EX_Opcode = 2'b00;
    ID_EX_Rd = 3'd0;
    Mem_Busy = 1'b0;

    // reset state
    step(0, 8'h00, 2'b00, 3'd0, 0, C_RST,  0, 8'd0, 8'h00);
    step(0, 8'h59, 2'b10, 3'd3, 1, C_RST,  0, 8'd0, 8'h19);
    // normal flow and non-matching load
    step(1, 8'h00, 2'b00, 3'd0, 0, C_NORM, 0, 8'd0, 8'h00);
    step(1, 8'h59, 2'b10, 3'd5, 0, C_NORM, 0, 8'd0, 8'h19);
    // load-use on ADD rd: two stall cycles then RUN
    step(1, 8'h59, 2'b10, 3'd3, 0, C_STALL, 0, 8'd0, 8'h19);
    step(1, 8'h59, 2'b10, 3'd3, 0, C_STALL, 0, 8'd1, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 0, C_NORM,  0, 8'd2, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 0, C_NORM,  0, 8'd2, 8'h19);
    // load-use on MOV rs, second stall regardless of hazard input
    step(1, 8'h03, 2'b10, 3'd3, 0, C_STALL, 0, 8'd2, 8'h03);
    step(1, 8'h03, 2'b00, 3'd0, 0, C_STALL, 0, 8'd3, 8'h03);
    step(1, 8'h03, 2'b00, 3'd0, 0, C_NORM,  0, 8'd4, 8'h03);
    // LOAD does not read rd; JUMP reads nothing
    step(1, 8'h9A, 2'b10, 3'd3, 0, C_NORM,  0, 8'd4, 8'h1A);
    step(1, 8'hC5, 2'b10, 3'd5, 0, C_JMP,   0, 8'd4, 8'h05);
    step(1, 8'h00, 2'b00, 3'd0, 0, C_NORM,  0, 8'd4, 8'h00);
    // freeze during LU_STALL
    step(1, 8'h59, 2'b10, 3'd3, 0, C_STALL, 0, 8'd4, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd5, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd6, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd7, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 0, C_STALL, 0, 8'd8, 8'h19);
    step(1, 8'h59, 2'b00, 3'd0, 0, C_NORM,  0, 8'd9, 8'h19);
    // freeze masks a jump
    step(1, 8'hC5, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd9,  8'h05);
    step(1, 8'hC5, 2'b00, 3'd0, 0, C_JMP,   0, 8'd10, 8'h05);
    step(1, 8'h00, 2'b00, 3'd0, 0, C_NORM,  0, 8'd10, 8'h00);
    // Mem_Busy timeout after 12 cycles
    for (int k = 0; k < 12; k++)
      step(1, 8'h00, 2'b00, 3'd0, 1, C_FRZ, 0, 8'(10 + k), 8'h00);
    step(1, 8'h00, 2'b00, 3'd0, 0, C_HALT, 1, 8'd21, 8'h00);
    step(1, 8'h59, 2'b10, 3'd3, 1, C_HALT, 1, 8'd21, 8'h19);
    step(0, 8'h00, 2'b00, 3'd0, 0, C_RST,  0, 8'd0,  8'h00);
    // reset mid-wait and mid-LU_STALL
    step(1, 8'h00, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd0, 8'h00);
    step(1, 8'h00, 2'b00, 3'd0, 1, C_FRZ,   0, 8'd1, 8'h00);
    step(0, 8'h00, 2'b00, 3'd0, 1, C_RST,   0, 8'd0, 8'h00);
    step(1, 8'h00, 2'b00, 3'd0, 0, C_NORM,  0, 8'd0, 8'h00);
    step(1, 8'h59, 2'b10, 3'd3, 0, C_STALL, 0, 8'd0, 8'h19);
    step(0, 8'h59, 2'b10, 3'd3, 0, C_RST,   0, 8'd0, 8'h19);
    step(1, 8'h00, 2'b00, 3'd0, 0, C_NORM,  0, 8'd0, 8'h00);
    // halt instruction
    step(1, 8'hC0, 2'b00, 3'd0, 0, C_HLTI, 0, 8'd0, 8'h00);
    step(1, 8'h59, 2'b10, 3'd3, 1, C_HALT, 0, 8'd0, 8'h19);
    step(1, 8'hC5, 2'b00, 3'd0, 0, C_HALT, 0, 8'd0, 8'h05);
    step(0, 8'h00, 2'b00, 3'd0, 0, C_RST,  0, 8'd0, 8'h00);
    // Stall_Cnt saturation under continuous load-use stalls
    for (int k = 0; k < 300; k++)
      step(1, 8'h59, 2'b10, 3'd3, 0, C_STALL, 0, (k > 255) ? 8'hFF : 8'(k), 8'h19);

    repeat (2) @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 12, max consecutive Mem_Busy cycles tolerated before timeout (range 2..15).
REQ-002 SHALL have port: Clk  input  1  single system clock, all state updates on posedge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: IF_ID_Instruction_Code  input  8  instruction in decode stage.
REQ-005 SHALL have port: ID_EX_Opcode  input  2  opcode of instruction in execute stage.
REQ-006 SHALL have port: ID_EX_Rd  input  3  destination register of instruction in execute stage.
REQ-007 SHALL have port: Mem_Busy  input  1  data memory requests pipeline freeze.
REQ-008 SHALL have port: PC_Write  output  1  PC update enable.
REQ-009 SHALL have port: IF_ID_Write  output  1  IF/ID register load enable.
REQ-010 SHALL have port: IF_ID_Flush  output  1  IF/ID register loads 8'h00 (NOP) at next edge.
REQ-011 SHALL have port: ID_EX_Bubble  output  1  ID/EX register loads NOP at next edge.
REQ-012 SHALL have port: Pipe_Freeze  output  1  all pipeline registers hold.
REQ-013 SHALL have port: Jump_Sel  output  1  PC source = Jump_Target.
REQ-014 SHALL have port: Jump_Target  output  8  {2'b00, IF_ID_Instruction_Code[5:0]}.
REQ-015 SHALL have port: Halted  output  1  controller in HALT.
REQ-016 SHALL have port: Timeout_Err  output  1  sticky Mem_Busy timeout flag.
REQ-017 SHALL have port: Stall_Cnt  output  8  saturating count of stalled cycles.

Function
REQ-018 SHALL decode instruction as op=[7:6], rd=[5:3], rs=[2:0]; op 00 MOV (reads rs), 01 ADD (reads rd, rs), 10 LOAD (reads rs), 11 JUMP (reads none).
REQ-019 SHALL have states RUN, LU_STALL, HALT held in registers; outputs combinational from state and current inputs.
REQ-020 SHALL define hazard = (ID_EX_Opcode==2'b10) and ID_EX_Rd equal to a register read by the IF_ID instruction.
REQ-021 SHALL apply priority per cycle: HALT > Mem_Busy freeze > load-use stall > jump > normal.
REQ-022 SHALL in RUN, no event: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
REQ-023 SHALL, when Mem_Busy=1 outside HALT: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, Bubble=0, Flush=0, Jump_Sel=0; state unchanged.
REQ-024 SHALL on hazard in RUN (no freeze): PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next state LU_STALL.
REQ-025 SHALL in LU_STALL (no freeze): PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 regardless of hazard input; next state RUN (total 2 stall cycles per load-use).
REQ-026 SHALL on JUMP with offset!=0 in RUN (no freeze): Jump_Sel=1, PC_Write=1, IF_ID_Flush=1, IF_ID_Write=1.
REQ-027 SHALL on IF_ID_Instruction_Code==8'hC0 in RUN (no freeze): enter HALT next edge; that cycle PC_Write=0, IF_ID_Write=0.
REQ-028 SHALL in HALT: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, Halted=1; exit only via Reset.
REQ-029 SHALL count consecutive Mem_Busy cycles in a 4-bit Wait_Cnt, cleared whenever Mem_Busy=0.
REQ-030 SHALL, when Mem_Busy=1 and Wait_Cnt==MAX_WAIT-1, set Timeout_Err=1 and enter HALT next edge.
REQ-031 SHALL increment Stall_Cnt each edge where PC_Write=0 and state!=HALT and next state!=HALT, saturating at 8'hFF.
REQ-032 SHALL keep Jump_Target driven continuously, independent of Jump_Sel.

Reset
REQ-033 SHALL on Reset=0 immediately set state RUN, Wait_Cnt=0, Stall_Cnt=0, Timeout_Err=0, independent of Clk.
REQ-034 SHALL while Reset=0 drive PC_Write=0, IF_ID_Write=0, Pipe_Freeze=0, Bubble=0, Flush=0, Jump_Sel=0, Halted=0.
REQ-035 SHALL on Reset deassertion mid-LU_STALL or mid-wait resume in RUN with no residual stall.

Verification
REQ-036 SHALL cover: ID_EX LOAD rd=3, IF_ID ADD 8'b01_011_001 -> 2 cycles PC_Write=0, Bubble=1, then RUN; Stall_Cnt=2.
REQ-037 SHALL cover: IF_ID 8'hC5 (JUMP 5) in RUN -> Jump_Sel=1, Flush=1, Jump_Target=8'h05 for one cycle.
REQ-038 SHALL cover: Mem_Busy=1 asserted during LU_STALL for 3 cycles -> Pipe_Freeze=1 3 cycles, then one Bubble cycle, then RUN.
REQ-039 SHALL cover: Mem_Busy held 12 cycles (MAX_WAIT=12) -> Timeout_Err=1, Halted=1 after 12th edge; Reset=0 clears both asynchronously.
REQ-040 SHALL cover: IF_ID 8'hC0 -> HALT, Bubble=1 held; 300 stall-eligible cycles elsewhere -> Stall_Cnt saturates at 8'hFF.
